// File: rtl/spi_slave_buf.sv
// ---------------------------------------------------------------------------
// spi_slave_buf
// SPI mode-0 slave with an 8-entry receive buffer and an 8-entry locally
// loaded transmit buffer. The SPI pins are oversampled in the i_clk domain
// through 2-flop synchronisers. Edge actions land 3 clk after the pin edge.
//
// Ports:
//   i_clk, i_rst_n        system clock (rising edge), async active-low reset
//   i_mclk, i_cs, i_mosi  SPI pins from the master (mclk idle low, cs active low)
//   o_miso                serial data back to the master, MSB first
//   i_wen/i_wadd/i_wdata  local write port into the tx buffer
//   i_radd/o_rdata        local read port of the rx buffer (1-clk latency)
//   o_byte_valid          one-clk pulse per completed received byte
//   o_rx_byte             last completed received byte
//   o_rx_count            bytes received in current/last frame, saturates at 8
//   o_overrun             sticky: more than 8 bytes in the current frame
//   o_frame_err           one-clk pulse when cs rises mid-byte
// ---------------------------------------------------------------------------
module spi_slave_buf #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mclk,
    input  logic              i_cs,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_wadd,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_radd,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_byte_valid,
    output logic [DATA_W-1:0] o_rx_byte,
    output logic [ADDR_W:0]   o_rx_count,
    output logic              o_overrun,
    output logic              o_frame_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        BIT_ONE  = 3'd1;
    localparam logic [2:0]        BIT_LAST = 3'd7;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t r_state, w_state_next;

    // Synchroniser chains; the extra *_d flop on mclk and cs is the previous
    // synchronised value used for edge detection. They reset low so that a
    // cs already held low when reset is released never looks like a fall.
    logic r_mclk_s1, r_mclk_s2, r_mclk_d;
    logic r_cs_s1, r_cs_s2, r_cs_d;
    logic r_mosi_s1, r_mosi_s2;

    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [DATA_W-1:0] r_shift_rx, r_shift_tx;
    logic [ADDR_W-1:0] r_ptr;
    logic [2:0]        r_bit_cnt;

    logic              w_mclk_rise, w_mclk_fall, w_cs_fall, w_cs_rise;
    logic              w_byte_done;
    logic [DATA_W-1:0] w_rx_next;
    logic [ADDR_W-1:0] w_ptr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mclk_s1 <= 1'b0; r_mclk_s2 <= 1'b0; r_mclk_d <= 1'b0;
            r_cs_s1   <= 1'b0; r_cs_s2   <= 1'b0; r_cs_d   <= 1'b0;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
        end else begin
            r_mclk_s1 <= i_mclk; r_mclk_s2 <= r_mclk_s1; r_mclk_d <= r_mclk_s2;
            r_cs_s1   <= i_cs;   r_cs_s2   <= r_cs_s1;   r_cs_d   <= r_cs_s2;
            r_mosi_s1 <= i_mosi; r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_mclk_rise = r_mclk_s2 & ~r_mclk_d;
    assign w_mclk_fall = ~r_mclk_s2 & r_mclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

    // The 3-bit bit counter wraps 7 -> 0 on the eighth rise, so "bit_cnt
    // reaching 8" is the rise seen while the counter still reads 7.
    assign w_byte_done = (r_state == ST_SHIFT) && w_mclk_rise && (r_bit_cnt == BIT_LAST);
    assign w_rx_next   = {r_shift_rx[DATA_W-2:0], r_mosi_s2};
    assign w_ptr_next  = r_ptr + PTR_ONE;

    assign o_miso = (r_state == ST_SHIFT) ? r_shift_tx[DATA_W-1] : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_cs_rise) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Transmit buffer: the local port may write at any time. A load into
    // shift_tx in the same clk reads the pre-write contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_tx_mem[i] <= '0;
        end else if (i_wen) begin
            r_tx_mem[i_wadd] <= i_wdata;
        end
    end

    // Shift datapath, rx buffer and status. A cs rise in the same clk as a
    // byte completion still stores the byte and is not a framing error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_rx_mem[i] <= '0;
            r_shift_rx   <= '0;
            r_shift_tx   <= '0;
            r_ptr        <= '0;
            r_bit_cnt    <= '0;
            o_rdata      <= '0;
            o_byte_valid <= 1'b0;
            o_rx_byte    <= '0;
            o_rx_count   <= '0;
            o_overrun    <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_rdata      <= r_rx_mem[i_radd];
            if (r_state == ST_IDLE) begin
                if (w_cs_fall) begin
                    r_ptr      <= '0;
                    r_bit_cnt  <= '0;
                    r_shift_rx <= '0;
                    o_rx_count <= '0;
                    o_overrun  <= 1'b0;
                    r_shift_tx <= r_tx_mem[0];
                end
            end else begin
                if (w_byte_done) begin
                    r_rx_mem[r_ptr] <= w_rx_next;
                    o_rx_byte       <= w_rx_next;
                    o_byte_valid    <= 1'b1;
                    if (o_rx_count == CNT_FULL) o_overrun  <= 1'b1;
                    else                        o_rx_count <= o_rx_count + CNT_ONE;
                    r_ptr      <= w_ptr_next;
                    r_bit_cnt  <= '0;
                    r_shift_tx <= r_tx_mem[w_ptr_next];
                end else if (w_mclk_rise) begin
                    r_shift_rx <= w_rx_next;
                    r_bit_cnt  <= r_bit_cnt + BIT_ONE;
                end else if (w_mclk_fall && (r_bit_cnt != '0)) begin
                    r_shift_tx <= {r_shift_tx[DATA_W-2:0], 1'b0};
                end
                // A partial byte is simply dropped by clearing the counter.
                if (w_cs_rise && !w_byte_done) begin
                    if ((r_bit_cnt != '0) || w_mclk_rise) o_frame_err <= 1'b1;
                    r_bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: doc/spi_slave_buf.md
Name: spi_slave_buf

Overview:
SPI mode-0 slave that sits directly downstream of the team's SPI master and consumes its mosi/mclk/cs pins. It oversamples the SPI pins in the system clock domain. It shifts received bytes into an 8-entry receive buffer and returns bytes from an 8-entry locally loaded transmit buffer on miso. Local logic reads received bytes and loads response bytes through simple register-file ports.

Parameters:
DATA_W, 8, bits per SPI byte and buffer entry width
ADDR_W, 3, buffer address width; depth = 2**ADDR_W = 8

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  asynchronous, active-low reset
mclk  input  1  SPI clock from master, idle low
cs  input  1  chip select from master, active low
mosi  input  1  serial data from master, MSB first
miso  output  1  serial data to master, MSB first
wen  input  1  local write strobe into tx buffer
wadd  input  3  tx buffer write address
wdata  input  8  tx buffer write data
radd  input  3  rx buffer read address
rdata  output  8  rx buffer read data, registered
byte_valid  output  1  one-clk pulse per completed received byte
rx_byte  output  8  last completed received byte
rx_count  output  4  bytes received in current/last frame, 0..8 saturating
overrun  output  1  sticky: more than 8 bytes in current frame
frame_err  output  1  one-clk pulse: cs deasserted mid-byte

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; ptr=0; bit_cnt=0; rx/tx buffers cleared to 0x00.
- mclk, cs, mosi pass through 2-flop synchronisers. Edges are detected on the synchronised values. Action occurs 3 clk after the pin edge.
- Operating constraints: mclk high and low phases are each ≥4 clk. cs falls ≥4 clk before the first mclk rise.
- FSM states:
  - IDLE: miso=0.
    - On sync cs fall: ptr=0, bit_cnt=0, rx_count=0, overrun=0, shift_tx=tx_mem[0]. Next state SHIFT.
    - miso shows shift_tx[7] on the next clk.
  - SHIFT, sync mclk rise: shift_rx={shift_rx[6:0],mosi_s}; bit_cnt++.
  - SHIFT, bit_cnt reaching 8 (byte complete):
    - rx_mem[ptr]=byte; rx_byte=byte; byte_valid pulses 1 clk.
    - rx_count=min(rx_count+1,8).
    - If rx_count was already 8, overrun=1.
    - ptr=ptr+1 mod 8; bit_cnt=0; shift_tx=tx_mem[new ptr].
  - SHIFT, sync mclk fall with bit_cnt≠0: shift_tx shifts left 1. miso=shift_tx[7].
  - SHIFT, sync mclk fall with bit_cnt=0 (following byte completion): miso already holds new shift_tx[7]; no shift.
  - SHIFT, sync cs rise:
    - If bit_cnt≠0: the partial byte is discarded (rx_mem untouched) and frame_err pulses 1 clk.
    - rx_count and overrun hold until the next frame start.
    - Next state IDLE; miso=0.
- Wrap-around: the 9th byte of a frame overwrites rx_mem[0] and is transmitted from tx_mem[0]. Further bytes continue cyclically.
- Simultaneous events:
  - cs rise in the same clk as byte completion: the byte is stored, then IDLE. No frame_err.
  - Local wen to tx address X in the same clk as a load from X: the loaded byte is the old value. The new value is used on the next load.
  - wen is accepted in any state.
- rdata = rx_mem[radd] registered, 1-clk latency. A read of an address written in the same clk returns the old value.
- rx_byte holds its value until the next completed byte.
- Reset mid-frame: immediate clear. The block waits for a fresh cs fall; the current low cs is ignored until it rises.

Test Plan:
- Reset: hold rst=0 with pins toggling → miso=0, rdata=0x00, rx_count=0, overrun=0, byte_valid=0, frame_err=0. Reads of all 8 rx addresses return 0x00.
- Single byte: load tx_mem[0]=0x12. Frame: cs low, master sends 0xA5 with mclk period 10 clk, cs high.
  - miso bits sampled at mclk rises are 0,0,0,1,0,0,1,0.
  - One byte_valid pulse; rx_byte=0xA5; rx_count=1.
  - radd=0 → rdata=0xA5 one clk later.
- Full buffer: tx_mem[0..7]=0xF0..0x12 (descending). Master sends 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 in one frame.
  - rx_mem[0..7] holds that sequence.
  - rx_count=8; overrun=0; 8 byte_valid pulses.
  - miso returns tx_mem[0..7] in order.
- Overrun: 9-byte frame, 9th byte 0x55 → rx_mem[0]=0x55, rx_count=8, overrun=1. The next cs fall clears overrun and rx_count.
- Abort: cs rises after 5 mclk rises of byte 0x3C → frame_err pulses once, no byte_valid, rx_mem unchanged, miso=0.
- Reset mid-frame: assert rst after 3 bytes with cs held low → all cleared. No activity until cs rises and falls again. The next frame writes starting at rx_mem[0].
